// File: rtl/of_pkg.sv
// Shared SimpleRISC decode constants and the OF/EX register layout.
// Latency: none (declarations and pure functions only).
// Backpressure: none.
package of_pkg;

  // Architectural register index width (16 registers).
  localparam int REG_IDX_W = 4;

  // SimpleRISC opcodes.
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_MOD  = 5'd4,
    OP_CMP  = 5'd5,
    OP_AND  = 5'd6,
    OP_OR   = 5'd7,
    OP_NOT  = 5'd8,
    OP_MOV  = 5'd9,
    OP_LSL  = 5'd10,
    OP_LSR  = 5'd11,
    OP_ASR  = 5'd12,
    OP_NOP  = 5'd13,
    OP_LD   = 5'd14,
    OP_ST   = 5'd15,
    OP_BEQ  = 5'd16,
    OP_BGT  = 5'd17,
    OP_B    = 5'd18,
    OP_CALL = 5'd19,
    OP_RET  = 5'd20
  } opcode_e;

  // Immediate modifier encodings; 2'b11 is decoded like MOD_SEXT.
  localparam logic [1:0] MOD_SEXT = 2'b00;
  localparam logic [1:0] MOD_UNS  = 2'b01;
  localparam logic [1:0] MOD_HI   = 2'b10;

  // Return-address register used implicitly by RET.
  localparam logic [REG_IDX_W-1:0] REG_RA = 4'd15;

  // Encoding of "nop" injected on a squash.
  localparam logic [31:0] NOP_INSTR = 32'h6800_0000;

  // Instruction field positions.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 22;
  localparam int RS1_MSB = 21;
  localparam int RS1_LSB = 18;
  localparam int RS2_MSB = 17;
  localparam int RS2_LSB = 14;
  localparam int IMM_MSB = 17;
  localparam int OFF_MSB = 26;

  // OF/EX pipeline register contents.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] branch_target;
    logic [31:0] immx;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        valid;
  } ofex_t;

  // Bubble loaded on a squash: a real NOP encoding, everything else zero.
  localparam ofex_t OFEX_BUBBLE = '{
    pc:            32'h0,
    instr:         NOP_INSTR,
    branch_target: 32'h0,
    immx:          32'h0,
    op1:           32'h0,
    op2:           32'h0,
    valid:         1'b0
  };

  // Expand the 18-bit immediate field according to its modifier bits.
  function automatic logic [31:0] expand_imm(input logic [IMM_MSB:0] imm);
    logic [31:0] r;
    case (imm[17:16])
      MOD_UNS: r = {16'h0000, imm[15:0]};
      MOD_HI:  r = {imm[15:0], 16'h0000};
      default: r = {{16{imm[15]}}, imm[15:0]};
    endcase
    return r;
  endfunction

  // Sign-extend the 27-bit branch offset to a full word.
  function automatic logic [31:0] sext_offset(input logic [OFF_MSB:0] off);
    return {{(31 - OFF_MSB){off[OFF_MSB]}}, off};
  endfunction

endpackage

// File: rtl/of_stage_register_file.sv
// 16x32 register file: two asynchronous read ports, one synchronous write port (OF_BYPASS_EN enables write-through).
// Latency: reads combinational; writes visible to reads after the next clk edge (same cycle with OF_BYPASS_EN).
// Backpressure: none; the write port is always accepted.
module register_file #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [AW-1:0]   rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage: async clear of every register, otherwise write on the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: stored value, or the in-flight write data when forwarding is built in.
  always_comb begin
    ra_data = regs[ra_addr];
    rb_data = regs[rb_addr];
`ifdef OF_BYPASS_EN
    if (wr_en && (wr_addr == ra_addr)) ra_data = wr_data;
    if (wr_en && (wr_addr == rb_addr)) rb_data = wr_data;
`endif
  end

endmodule

// File: rtl/of_stage.sv
// Operand fetch: decode, register read, immediate/branch-target build into OF/EX (OF_BYPASS_EN: WB forwarding).
// Latency: 1 cycle from pc_in/instruction_in to the OF/EX outputs.
// Backpressure: stall holds OF/EX; flush loads a NOP bubble and wins over stall.
module of_stage
  import of_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [XLEN-1:0]          pc_in,
  input  logic [XLEN-1:0]          instruction_in,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  output logic [XLEN-1:0]          pc_out,
  output logic [XLEN-1:0]          instruction_out,
  output logic [XLEN-1:0]          branch_target_out,
  output logic [XLEN-1:0]          immx_out,
  output logic [XLEN-1:0]          op1_out,
  output logic [XLEN-1:0]          op2_out,
  output logic                     valid_out
);

  logic [OPC_MSB-OPC_LSB:0] opcode;
  logic [REG_IDX_W-1:0]     rd;
  logic [REG_IDX_W-1:0]     rs1;
  logic [REG_IDX_W-1:0]     rs2;
  logic [REG_IDX_W-1:0]     a_addr;
  logic [REG_IDX_W-1:0]     b_addr;
  logic [XLEN-1:0]          a_data;
  logic [XLEN-1:0]          b_data;
  ofex_t                    ofex_d;
  ofex_t                    ofex_q;

  assign opcode = instruction_in[OPC_MSB:OPC_LSB];
  assign rd     = instruction_in[RD_MSB:RD_LSB];
  assign rs1    = instruction_in[RS1_MSB:RS1_LSB];
  assign rs2    = instruction_in[RS2_MSB:RS2_LSB];

  // Port A reads the return address for RET; port B reads the store data register for ST.
  always_comb begin
    a_addr = rs1;
    b_addr = rs2;
    if (opcode == OP_RET) a_addr = REG_RA;
    if (opcode == OP_ST)  b_addr = rd;
  end

  register_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (a_addr),
    .ra_data (a_data),
    .rb_addr (b_addr),
    .rb_data (b_data),
    .wr_en   (wb_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data)
  );

  // Assemble the next OF/EX contents; branch target wraps modulo 2^32.
  always_comb begin
    ofex_d               = '0;
    ofex_d.pc            = pc_in;
    ofex_d.instr         = instruction_in;
    ofex_d.branch_target = pc_in + sext_offset(instruction_in[OFF_MSB:0]);
    ofex_d.immx          = expand_imm(instruction_in[IMM_MSB:0]);
    ofex_d.op1           = a_data;
    ofex_d.op2           = b_data;
    ofex_d.valid         = 1'b1;
  end

  // OF/EX register: reset clears to zero, flush inserts a bubble, stall holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ofex_q <= '0;
    end else if (flush) begin
      ofex_q <= OFEX_BUBBLE;
    end else if (!stall) begin
      ofex_q <= ofex_d;
    end
  end

  assign pc_out            = ofex_q.pc;
  assign instruction_out   = ofex_q.instr;
  assign branch_target_out = ofex_q.branch_target;
  assign immx_out          = ofex_q.immx;
  assign op1_out           = ofex_q.op1;
  assign op2_out           = ofex_q.op2;
  assign valid_out         = ofex_q.valid;

endmodule

// File: tb/tb_of_stage.sv
// Self-checking bench for of_stage: scoreboard queue fed by the driver, drained by a monitor.
// Latency: expected entries are checked 2 time units after the capturing clock edge.
// Backpressure: stall/flush are driven directly; the reference model applies hold/bubble rules.
`timescale 1ns/1ps
module tb_of_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [31:0] branch_target_out;
  logic [31:0] immx_out;
  logic [31:0] op1_out;
  logic [31:0] op2_out;
  logic        valid_out;

  always #5 clk = ~clk;

  of_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .pc_in             (pc_in),
    .instruction_in    (instruction_in),
    .wb_en             (wb_en),
    .wb_addr           (wb_addr),
    .wb_data           (wb_data),
    .pc_out            (pc_out),
    .instruction_out   (instruction_out),
    .branch_target_out (branch_target_out),
    .immx_out          (immx_out),
    .op1_out           (op1_out),
    .op2_out           (op2_out),
    .valid_out         (valid_out)
  );

`ifdef OF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] bt;
    logic [31:0] immx;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        vld;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        held;
  logic [31:0] mr [16];
  int          checks = 0;
  int          errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t zero_state();
    exp_t e;
    e = '{pc: 32'h0, instr: 32'h0, bt: 32'h0, immx: 32'h0, op1: 32'h0, op2: 32'h0, vld: 1'b0};
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    return {op[4:0], 1'b0, rd[3:0], rs1[3:0], rs2[3:0], 14'h0};
  endfunction

  // Register read as seen by OF this cycle (before the edge's write lands).
  function automatic logic [31:0] model_read(input int idx, input logic we, input logic [3:0] wa,
                                             input logic [31:0] wd);
    if (BYPASS && we && (int'(wa) == idx)) return wd;
    return mr[idx];
  endfunction

  // Reference: what OF/EX should hold after capturing this instruction.
  function automatic exp_t model_capture(input logic [31:0] pc, input logic [31:0] instr,
                                         input logic we, input logic [3:0] wa, input logic [31:0] wd);
    exp_t        e;
    int          op;
    int          a;
    int          b;
    logic [31:0] imm16;
    logic [31:0] off;
    op    = int'(instr[31:27]);
    a     = (op == 20) ? 15 : int'(instr[21:18]);
    b     = (op == 15) ? int'(instr[25:22]) : int'(instr[17:14]);
    imm16 = {16'h0, instr[15:0]};
    off   = {5'h0, instr[26:0]};
    e.pc    = pc;
    e.instr = instr;
    e.vld   = 1'b1;
    case (instr[17:16])
      2'd1:    e.immx = imm16;
      2'd2:    e.immx = imm16 * 32'd65536;
      default: e.immx = (imm16 ^ 32'h0000_8000) - 32'h0000_8000;
    endcase
    e.bt  = pc + ((off ^ 32'h0400_0000) - 32'h0400_0000);
    e.op1 = model_read(a, we, wa, wd);
    e.op2 = model_read(b, we, wa, wd);
    return e;
  endfunction

  // Drive one cycle's inputs at a negedge, record the expectation, return at the next negedge.
  task automatic drive(input logic st, input logic fl, input logic [31:0] pc, input logic [31:0] instr,
                       input logic we, input logic [3:0] wa, input logic [31:0] wd);
    stall          = st;
    flush          = fl;
    pc_in          = pc;
    instruction_in = instr;
    wb_en          = we;
    wb_addr        = wa;
    wb_data        = wd;
    if (fl) begin
      held       = zero_state();
      held.instr = 32'h6800_0000;
    end else if (!st) begin
      held = model_capture(pc, instr, we, wa, wd);
    end
    sb_q.push_back(held);
    if (we) mr[wa] = wd;
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [3:0] wa, input logic [31:0] wd);
    drive(1'b0, 1'b0, 32'h0, enc_r(13, 0, 0, 0), 1'b1, wa, wd);
  endtask

  task automatic check_reset(input string tag);
    check32({tag, " pc"}, pc_out, 32'h0);
    check32({tag, " instr"}, instruction_out, 32'h0);
    check32({tag, " bt"}, branch_target_out, 32'h0);
    check32({tag, " immx"}, immx_out, 32'h0);
    check32({tag, " op1"}, op1_out, 32'h0);
    check32({tag, " op2"}, op2_out, 32'h0);
    check32({tag, " valid"}, {31'h0, valid_out}, 32'h0);
  endtask

  task automatic model_reset();
    sb_q.delete();
    held = zero_state();
    for (int i = 0; i < 16; i++) mr[i] = 32'h0;
  endtask

  // Monitor: compare every scoreboard entry shortly after the edge that produced it.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!rst && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check32("sb pc", pc_out, e.pc);
      check32("sb instr", instruction_out, e.instr);
      check32("sb bt", branch_target_out, e.bt);
      check32("sb immx", immx_out, e.immx);
      check32("sb op1", op1_out, e.op1);
      check32("sb op2", op2_out, e.op2);
      check32("sb valid", {31'h0, valid_out}, {31'h0, e.vld});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic [4:0]  op;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; pc_in = '0; instruction_in = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset("power-on rst");

    // Preload registers, then reset asynchronously in the middle of a cycle.
    rst = 1'b0;
    wb_write(4'd5, 32'h0000_1234);
    wb_write(4'd6, 32'h0000_5678);
    drive(1'b0, 1'b0, 32'h44, enc_r(0, 1, 5, 6), 1'b0, 4'd0, 32'h0);
    #2 rst = 1'b1;
    #1 check_reset("async rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h8, enc_r(0, 1, 5, 6), 1'b0, 4'd0, 32'h0);
    check32("r5 after rst", op1_out, 32'h0);

    // add r1,r2,r3
    wb_write(4'd2, 32'd7);
    wb_write(4'd3, 32'd9);
    drive(1'b0, 1'b0, 32'h10, enc_r(0, 1, 2, 3), 1'b0, 4'd0, 32'h0);
    check32("add op1", op1_out, 32'd7);
    check32("add op2", op2_out, 32'd9);
    check32("add pc", pc_out, 32'h10);
    check32("add valid", {31'h0, valid_out}, 32'h1);

    // Immediate modifiers.
    drive(1'b0, 1'b0, 32'h14, {5'd9, 1'b1, 4'd1, 18'h0FFFF}, 1'b0, 4'd0, 32'h0);
    check32("immx sext", immx_out, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 32'h18, {5'd9, 1'b1, 4'd1, 18'h1FFFF}, 1'b0, 4'd0, 32'h0);
    check32("immx uns", immx_out, 32'h0000_FFFF);
    drive(1'b0, 1'b0, 32'h1C, {5'd9, 1'b1, 4'd1, 18'h2FFFF}, 1'b0, 4'd0, 32'h0);
    check32("immx hi", immx_out, 32'hFFFF_0000);

    // Branch targets, negative offset and wraparound.
    drive(1'b0, 1'b0, 32'h20, {5'd18, 27'h7FF_FFFE}, 1'b0, 4'd0, 32'h0);
    check32("bt neg", branch_target_out, 32'h1E);
    drive(1'b0, 1'b0, 32'hFFFF_FFFE, {5'd18, 27'd5}, 1'b0, 4'd0, 32'h0);
    check32("bt wrap", branch_target_out, 32'h3);

    // Store data from rd, return address from r15.
    wb_write(4'd4, 32'hAB);
    drive(1'b0, 1'b0, 32'h30, {5'd15, 1'b1, 4'd4, 4'd1, 18'h8}, 1'b0, 4'd0, 32'h0);
    check32("st op2", op2_out, 32'hAB);
    wb_write(4'd15, 32'h40);
    drive(1'b0, 1'b0, 32'h34, {5'd20, 27'h0}, 1'b0, 4'd0, 32'h0);
    check32("ret op1", op1_out, 32'h40);

    // Stall three cycles while WB rewrites the held source register.
    drive(1'b0, 1'b0, 32'h100, enc_r(0, 1, 2, 3), 1'b0, 4'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h200 + i, enc_r(1, 3, 4, 4), 1'b1, 4'd2, 32'h99);
      check32("stall pc", pc_out, 32'h100);
      check32("stall op1", op1_out, 32'd7);
      check32("stall valid", {31'h0, valid_out}, 32'h1);
    end

    // Flush with stall: bubble wins.
    drive(1'b1, 1'b1, 32'h300, enc_r(0, 1, 2, 3), 1'b0, 4'd0, 32'h0);
    check32("flush valid", {31'h0, valid_out}, 32'h0);
    check32("flush instr", instruction_out, 32'h6800_0000);
    check32("flush pc", pc_out, 32'h0);

    // Same-cycle writeback and read of r2.
    wb_write(4'd2, 32'h11);
    drive(1'b0, 1'b0, 32'h400, enc_r(0, 1, 2, 3), 1'b1, 4'd2, 32'h55);
    check32("bypass op1", op1_out, BYPASS ? 32'h55 : 32'h11);
    drive(1'b0, 1'b0, 32'h404, enc_r(0, 1, 2, 3), 1'b0, 4'd0, 32'h0);
    check32("after wb op1", op1_out, 32'h55);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      r  = $urandom();
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 20));
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom(), {op, r[26:0]},
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
    end

    check32("scoreboard drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
